// File: rtl/flash_cmd_sequencer.sv
// Parallel-flash command sequencer: expands one accepted command into JEDEC
// bus cycles (byte selects, address source, data enables, CE_N/WE_N/OE_N).
module flash_cmd_sequencer #(
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_PULSE = 2,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_READ  = 2,
  parameter int unsigned T_PROG  = 20,
  parameter int unsigned T_ERASE = 100,
  parameter int unsigned CW      = 16
) (
  input  logic       SCL,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       selAA,
  output logic       sel55,
  output logic       selB0,
  output logic       selC0,
  output logic       selD0,
  output logic       selE0,
  output logic       sel00,
  output logic       selData,
  output logic       EnDataOut,
  output logic       EnDataIn,
  output logic       selAddr,
  output logic [1:0] addr_sel,
  output logic       CE_N,
  output logic       WE_N,
  output logic       OE_N
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_W_GAP,
    S_R_SETUP, S_R_PULSE, S_WAIT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_READ = 3'd0, OP_PROG = 3'd1, OP_SERASE = 3'd2, OP_CERASE = 3'd3, OP_SRST = 3'd4
  } op_t;

  typedef enum logic [3:0] {
    B_NONE, B_AA, B_55, B_B0, B_C0, B_D0, B_E0, B_00, B_DATA
  } byte_t;

  localparam logic [1:0]    A_5555  = 2'd0;
  localparam logic [1:0]    A_2AAA  = 2'd1;
  localparam logic [1:0]    A_TGT   = 2'd2;
  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP);
  localparam logic [CW-1:0] L_PULSE = CW'(T_PULSE);
  localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD);
  localparam logic [CW-1:0] L_READ  = CW'(T_READ);
  localparam logic [CW-1:0] L_PROG  = CW'(T_PROG);
  localparam logic [CW-1:0] L_ERASE = CW'(T_ERASE);

  state_t        r_state, w_state_nxt;
  op_t           r_op, w_op_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_step, w_step_nxt;
  logic          r_err, w_err_nxt;

  byte_t         w_byte;
  logic [1:0]    w_addr;
  logic          w_last;
  logic          w_cnt_end;

  assign w_cnt_end = (r_cnt == CW'(1));

  // NOTE: state uses non-blocking assignments and an asynchronous reset so an
  // abort forces every strobe high without waiting for an SCL edge.
  always_ff @(posedge SCL or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_READ;
      r_cnt   <= '0;
      r_step  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Byte/address of the current write step for the latched command.
  always_comb begin
    w_byte = B_NONE;
    w_addr = A_5555;
    w_last = 1'b0;
    case (r_op)
      OP_PROG: begin
        case (r_step)
          3'd0:    w_byte = B_AA;
          3'd1:    begin w_byte = B_55; w_addr = A_2AAA; end
          3'd2:    w_byte = B_B0;
          default: begin w_byte = B_DATA; w_addr = A_TGT; w_last = 1'b1; end
        endcase
      end
      OP_SERASE, OP_CERASE: begin
        case (r_step)
          3'd0, 3'd3: w_byte = B_AA;
          3'd1, 3'd4: begin w_byte = B_55; w_addr = A_2AAA; end
          3'd2:       w_byte = B_C0;
          default: begin
            w_last = 1'b1;
            if (r_op == OP_SERASE) begin
              w_byte = B_D0;
              w_addr = A_TGT;
            end else begin
              w_byte = B_E0;
            end
          end
        endcase
      end
      OP_SRST: begin
        w_byte = B_00;
        w_last = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_err_nxt   = 1'b0;

    busy = (r_state != S_IDLE) && (r_state != S_DONE);
    done = (r_state == S_DONE);
    err  = r_err;
    {selAA, sel55, selB0, selC0, selD0, selE0, sel00} = 7'b0;
    selData   = 1'b0;
    EnDataOut = 1'b0;
    EnDataIn  = 1'b0;
    selAddr   = 1'b0;
    addr_sel  = A_5555;
    CE_N      = 1'b1;
    WE_N      = 1'b1;
    OE_N      = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            3'd0: begin
              w_state_nxt = S_R_SETUP;
              w_op_nxt    = OP_READ;
              w_cnt_nxt   = L_SETUP;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
              w_state_nxt = S_W_SETUP;
              w_op_nxt    = op_t'(cmd_op);
              w_cnt_nxt   = L_SETUP;
              w_step_nxt  = '0;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      S_W_SETUP, S_W_PULSE, S_W_HOLD: begin
        CE_N     = 1'b0;
        WE_N     = (r_state != S_W_PULSE);
        addr_sel = w_addr;
        selAddr  = (w_addr == A_TGT);
        case (w_byte)
          B_AA:    selAA = 1'b1;
          B_55:    sel55 = 1'b1;
          B_B0:    selB0 = 1'b1;
          B_C0:    selC0 = 1'b1;
          B_D0:    selD0 = 1'b1;
          B_E0:    selE0 = 1'b1;
          B_00:    sel00 = 1'b1;
          B_DATA:  begin selData = 1'b1; EnDataOut = 1'b1; end
          default: ;
        endcase
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_cnt_end) begin
          case (r_state)
            S_W_SETUP: begin w_state_nxt = S_W_PULSE; w_cnt_nxt = L_PULSE; end
            S_W_PULSE: begin w_state_nxt = S_W_HOLD;  w_cnt_nxt = L_HOLD;  end
            default:   w_state_nxt = S_W_GAP;
          endcase
        end
      end
      S_W_GAP: begin
        w_step_nxt = r_step + 3'd1;
        if (!w_last) begin
          w_state_nxt = S_W_SETUP;
          w_cnt_nxt   = L_SETUP;
        end else if (r_op == OP_SRST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = (r_op == OP_PROG) ? L_PROG : L_ERASE;
        end
      end
      S_R_SETUP, S_R_PULSE: begin
        CE_N      = 1'b0;
        OE_N      = (r_state != S_R_PULSE);
        EnDataIn  = (r_state == S_R_PULSE) && w_cnt_end;
        selAddr   = 1'b1;
        addr_sel  = A_TGT;
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_cnt_end) begin
          if (r_state == S_R_SETUP) begin
            w_state_nxt = S_R_PULSE;
            w_cnt_nxt   = L_READ;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_cnt_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: table of commands, per-cycle expected outputs
// queued from a timing model, plus hand-written abort and invariant checks.
module tb_flash_cmd_sequencer;

  localparam int T_SETUP = 1;
  localparam int T_PULSE = 2;
  localparam int T_HOLD  = 1;
  localparam int T_READ  = 2;
  localparam int T_PROG  = 20;
  localparam int T_ERASE = 100;

  logic       SCL, reset, cmd_valid;
  logic [2:0] cmd_op;
  logic       busy, done, err;
  logic       selAA, sel55, selB0, selC0, selD0, selE0, sel00;
  logic       selData, EnDataOut, EnDataIn, selAddr;
  logic [1:0] addr_sel;
  logic       CE_N, WE_N, OE_N;

  flash_cmd_sequencer #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_READ(T_READ),
    .T_PROG(T_PROG), .T_ERASE(T_ERASE), .CW(16)
  ) dut (
    .SCL(SCL), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .busy(busy), .done(done), .err(err),
    .selAA(selAA), .sel55(sel55), .selB0(selB0), .selC0(selC0),
    .selD0(selD0), .selE0(selE0), .sel00(sel00),
    .selData(selData), .EnDataOut(EnDataOut), .EnDataIn(EnDataIn),
    .selAddr(selAddr), .addr_sel(addr_sel),
    .CE_N(CE_N), .WE_N(WE_N), .OE_N(OE_N)
  );

  // sel bits: [6]=AA [5]=55 [4]=B0 [3]=C0 [2]=D0 [1]=E0 [0]=00
  typedef struct packed {
    logic       busy, done, err;
    logic [6:0] sel;
    logic       sel_data, en_out, en_in, sel_addr;
    logic [1:0] addr_sel;
    logic       ce_n, we_n, oe_n;
  } obs_t;

  typedef struct {
    logic [2:0] op;
    int         done_at;
    bit         noise;
    string      name;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb[$];

  initial begin
    SCL = 1'b0;
    forever #5 SCL = ~SCL;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ce_n = 1'b1;
    o.we_n = 1'b1;
    o.oe_n = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.err = err;
    o.sel = {selAA, sel55, selB0, selC0, selD0, selE0, sel00};
    o.sel_data = selData; o.en_out = EnDataOut; o.en_in = EnDataIn;
    o.sel_addr = selAddr; o.addr_sel = addr_sel;
    o.ce_n = CE_N; o.we_n = WE_N; o.oe_n = OE_N;
    return o;
  endfunction

  task automatic step();
    @(posedge SCL);
    #1;
  endtask

  // Expected outputs for cycles 1..N after the accept edge.
  task automatic gen_trace(input logic [2:0] op);
    obs_t o, base;
    int   bytes[$];
    int   addrs[$];
    int   wait_n;
    if (op > 3'd4) begin
      o = idle_obs(); o.err = 1'b1;
      sb.push_back(o);
      sb.push_back(idle_obs());
      return;
    end
    if (op == 3'd0) begin
      base = idle_obs(); base.busy = 1'b1; base.ce_n = 1'b0;
      base.sel_addr = 1'b1; base.addr_sel = 2'd2;
      for (int i = 0; i < T_SETUP; i++) sb.push_back(base);
      for (int i = 0; i < T_READ; i++) begin
        o = base; o.oe_n = 1'b0; o.en_in = (i == T_READ - 1);
        sb.push_back(o);
      end
    end else begin
      case (op)
        3'd1:    begin bytes = '{6, 5, 4, -1}; addrs = '{0, 1, 0, 2}; wait_n = T_PROG; end
        3'd2:    begin bytes = '{6, 5, 3, 6, 5, 2}; addrs = '{0, 1, 0, 0, 1, 2}; wait_n = T_ERASE; end
        3'd3:    begin bytes = '{6, 5, 3, 6, 5, 1}; addrs = '{0, 1, 0, 0, 1, 0}; wait_n = T_ERASE; end
        default: begin bytes = '{0}; addrs = '{0}; wait_n = 0; end
      endcase
      for (int k = 0; k < bytes.size(); k++) begin
        base = idle_obs(); base.busy = 1'b1; base.ce_n = 1'b0;
        base.addr_sel = 2'(addrs[k]);
        base.sel_addr = (addrs[k] == 2);
        if (bytes[k] < 0) begin
          base.sel_data = 1'b1; base.en_out = 1'b1;
        end else begin
          base.sel[bytes[k]] = 1'b1;
        end
        for (int i = 0; i < T_SETUP; i++) sb.push_back(base);
        for (int i = 0; i < T_PULSE; i++) begin
          o = base; o.we_n = 1'b0; sb.push_back(o);
        end
        for (int i = 0; i < T_HOLD; i++) sb.push_back(base);
        o = idle_obs(); o.busy = 1'b1; sb.push_back(o);
      end
      for (int i = 0; i < wait_n; i++) begin
        o = idle_obs(); o.busy = 1'b1; sb.push_back(o);
      end
    end
    o = idle_obs(); o.done = 1'b1;
    sb.push_back(o);
  endtask

  task automatic run_cmd(input logic [2:0] op, input bit noise, input int done_at, input string name);
    obs_t e, a;
    int   cyc, done_seen;
    step();
    check({name, "_idle"}, sample(), idle_obs());
    cmd_valid = 1'b1;
    cmd_op    = op;
    gen_trace(op);
    cyc = 0;
    done_seen = 0;
    while (sb.size() > 0) begin
      step();
      cyc++;
      e = sb.pop_front();
      a = sample();
      check($sformatf("%s_c%0d", name, cyc), a, e);
      if (a.done) done_seen = cyc;
      if (noise && e.busy && $urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'($urandom_range(0, 7));
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check({name, "_done_cycle"}, done_seen, done_at);
  endtask

  // Bus invariants sampled mid-cycle throughout the run.
  always @(negedge SCL) begin
    check("inv_we_oe", {31'b0, ~WE_N & ~OE_N}, 32'd0);
    check("inv_strobe_ce", {31'b0, (~WE_N | ~OE_N) & CE_N}, 32'd0);
    check("inv_onehot", {31'b0, $countones({selAA, sel55, selB0, selC0, selD0, selE0, sel00, selData}) > 1}, 32'd0);
  end

  vec_t vecs[8];
  int   done_cnt, busy_cnt;

  initial begin
    vecs[0] = '{3'd1, 41,  1'b0, "program"};
    vecs[1] = '{3'd0, 4,   1'b0, "read"};
    vecs[2] = '{3'd3, 131, 1'b1, "chip_erase"};
    vecs[3] = '{3'd6, 0,   1'b0, "illegal6"};
    vecs[4] = '{3'd4, 6,   1'b0, "soft_reset"};
    vecs[5] = '{3'd2, 131, 1'b0, "sector_erase"};
    vecs[6] = '{3'd5, 0,   1'b0, "illegal5"};
    vecs[7] = '{3'd7, 0,   1'b0, "illegal7"};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
    repeat (2) @(posedge SCL);
    #1;
    check("reset_vals", sample(), idle_obs());
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle_%0d", i), sample(), idle_obs());
    end

    for (int v = 0; v < 8; v++) run_cmd(vecs[v].op, vecs[v].noise, vecs[v].done_at, vecs[v].name);

    // Abort sector erase while WE_N is low in the third write (C0@5555).
    step();
    cmd_valid = 1'b1; cmd_op = 3'd2;
    for (int c = 1; c <= 12; c++) begin
      step();
      cmd_valid = 1'b0;
    end
    check("abort_pre", {WE_N, CE_N, selC0}, 3'b001);
    #2 reset = 1'b1;
    #1 check("abort_async", sample(), idle_obs());
    @(posedge SCL);
    #1 reset = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 140; c++) begin
      step();
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_busy", busy_cnt, 0);
    run_cmd(3'd1, 1'b0, 41, "program_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
